// File: rtl/lfsr_gen.sv
// Parameterised Fibonacci/Galois LFSR with seed load, zero-seed rejection and
// optional cycle-length measurement (enabled by defining LFSR_GEN_PERIOD_EN).
module lfsr_gen #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int unsigned      MODE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state_out,
  output logic             bit_out,
  output logic             seed_err,
  output logic             wrap,
  output logic [WIDTH-1:0] period
);

  logic [WIDTH-1:0] state_q;
  logic             seed_err_q;
  logic [WIDTH-1:0] adv_c;
  logic [WIDTH-1:0] adv_safe_c;
  logic             seed_ok_c;
  logic [WIDTH-1:0] load_val_c;

  // One-step advance in the selected feedback form.
  always_comb begin
    adv_c = '0;
    if (MODE == 1) begin
      adv_c = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end else begin
      adv_c = {^(state_q & TAPS), state_q[WIDTH-1:1]};
    end
  end

  // A degenerate tap mask could produce zero; fall back to SEED so the register never locks up.
  always_comb begin
    adv_safe_c = adv_c;
    if (adv_c == '0) begin
      adv_safe_c = SEED;
    end
  end

  always_comb begin
    seed_ok_c  = |seed_in;
    load_val_c = seed_ok_c ? seed_in : SEED;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SEED;
      seed_err_q <= 1'b0;
    end else begin
      seed_err_q <= 1'b0;
      if (load) begin
        state_q    <= load_val_c;
        seed_err_q <= !seed_ok_c;
      end else if (en) begin
        state_q <= adv_safe_c;
      end
    end
  end

  assign state_out = state_q;
  assign bit_out   = state_q[0];
  assign seed_err  = seed_err_q;

`ifdef LFSR_GEN_PERIOD_EN
  logic [WIDTH-1:0] start_q;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] period_q;
  logic             wrap_q;

  // Cycle-length tracking relative to the most recent start value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      start_q  <= SEED;
      step_q   <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (load) begin
        start_q <= load_val_c;
        step_q  <= '0;
      end else if (en) begin
        if (adv_safe_c == start_q) begin
          wrap_q   <= 1'b1;
          period_q <= step_q + WIDTH'(1);
          step_q   <= '0;
        end else begin
          step_q <= step_q + WIDTH'(1);
        end
      end
    end
  end

  assign wrap   = wrap_q;
  assign period = period_q;
`else
  assign wrap   = 1'b0;
  assign period = '0;
`endif

endmodule
